turn_seq: RTL and testbench



---
 rtl/turn_seq_pkg.sv | 60 ++++++
 rtl/turn_seq_tick_gen.sv | 56 +++++
 rtl/turn_seq.sv | 167 ++++++++++++++++
 tb/tb_turn_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/turn_seq_pkg.sv
// -----------------------------------------------------------------------------
// turn_seq_pkg
// Shared types and helpers for the turn-signal sequencer.
//   mode_e        : decoded operating mode of the sequencer
//   fill_lsb()    : progressive fill pattern growing from bit 0 upwards
//   fill_msb()    : progressive fill pattern growing from bit lamps-1 downwards
//   presc_width() : counter width needed for a prescaler of tick_div states
// Patterns are returned 8 bits wide (the largest supported lamp count); bits at
// or above the lamp count are always zero.
// -----------------------------------------------------------------------------
package turn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        HAZARD = 3'd3,
        ERROR  = 3'd4
    } mode_e;

    localparam int MAX_LAMPS = 8;

    function automatic logic [7:0] fill_lsb(input int k, input int lamps);
        logic [7:0] res;
        res = 8'd0;
        for (int i = 0; i < MAX_LAMPS; i++) begin
            if ((i < k) && (i < lamps)) begin
                res[i] = 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] fill_msb(input int k, input int lamps);
        logic [7:0] res;
        res = 8'd0;
        for (int i = 0; i < MAX_LAMPS; i++) begin
            if ((i < lamps) && (i >= (lamps - k))) begin
                res[i] = 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    function automatic int presc_width(input int tick_div);
        int w;
        w = $clog2(tick_div);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/turn_seq_tick_gen.sv
// -----------------------------------------------------------------------------
// turn_tick_gen
// Step prescaler. Counts 0..TICK_DIV-1 and flags the cycle on which the count
// sits at TICK_DIV-1 so the sequencer advances on that edge.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   clear   : forces the count to 0 and suppresses tick (mode entry / idle)
//   tick    : high in the cycle whose closing edge advances the step
// tick is deliberately combinational: it has to coincide with the edge on
// which the counter wraps, and it only feeds the sequencer's own flops.
// -----------------------------------------------------------------------------
module turn_tick_gen
    import turn_seq_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int PW = presc_width(TICK_DIV);

    logic [PW-1:0] cnt_r;
    logic [PW-1:0] cnt_next_s;
    logic          at_end_s;

    // Wrap detection and next-count selection.
    always_comb begin
        at_end_s   = (cnt_r == PW'(TICK_DIV - 1));
        tick       = 1'b0;
        cnt_next_s = cnt_r;
        if (clear) begin
            tick       = 1'b0;
            cnt_next_s = '0;
        end else if (at_end_s) begin
            tick       = 1'b1;
            cnt_next_s = '0;
        end else begin
            tick       = 1'b0;
            cnt_next_s = cnt_r + PW'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/turn_seq.sv
// -----------------------------------------------------------------------------
// turn_seq
// Parametrised turn-signal sequencer with prescaled steps, hazard mode,
// registered error flag and optional brake overlay.
// Parameters:
//   LAMPS    : lamps per side (2..8)
//   TICK_DIV : clock cycles per sequence step (>=1)
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   left     : left turn request (synchronous level)
//   right    : right turn request (synchronous level)
//   hazard   : hazard request (synchronous level)
//   brake    : brake light request, present only with TURN_SEQ_BRAKE_EN
//   l_signal : left lamps, bit 0 innermost (registered)
//   r_signal : right lamps, bit LAMPS-1 innermost (registered)
//   error    : high while left and right are both requested (registered)
// Build option: define TURN_SEQ_BRAKE_EN to add the brake input and overlay.
// -----------------------------------------------------------------------------
module turn_seq
    import turn_seq_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
`ifdef TURN_SEQ_BRAKE_EN
    input  logic             brake,
`endif
    output logic [LAMPS-1:0] l_signal,
    output logic [LAMPS-1:0] r_signal,
    output logic             error
);

    mode_e            mode_r;
    mode_e            mode_s;
    logic [3:0]       step_r;
    logic [3:0]       step_next_s;
    logic             entry_s;
    logic             tick_s;
    logic             clear_s;
    logic             brake_s;
    logic [7:0]       lsb_s;
    logic [7:0]       msb_s;
    logic [LAMPS-1:0] l_next_s;
    logic [LAMPS-1:0] r_next_s;
    logic             err_next_s;
    logic             unused_s;

`ifdef TURN_SEQ_BRAKE_EN
    assign brake_s = brake;
`else
    assign brake_s = 1'b0;
`endif

    // Priority mode decode and mode-entry / prescaler-clear detection.
    always_comb begin
        if (hazard) begin
            mode_s = HAZARD;
        end else if (left && right) begin
            mode_s = ERROR;
        end else if (left) begin
            mode_s = LEFT;
        end else if (right) begin
            mode_s = RIGHT;
        end else begin
            mode_s = IDLE;
        end
        entry_s = (mode_s != mode_r);
        clear_s = entry_s || (mode_s == IDLE);
    end

    turn_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear_s),
        .tick    (tick_s)
    );

    // Step sequencing: 1 -> ... -> LAMPS -> 0 -> 1, restarted at 1 on entry.
    always_comb begin
        step_next_s = step_r;
        if (mode_s == IDLE) begin
            step_next_s = 4'd0;
        end else if (entry_s) begin
            step_next_s = 4'd1;
        end else if (tick_s) begin
            if (step_r == 4'(LAMPS)) begin
                step_next_s = 4'd0;
            end else begin
                step_next_s = step_r + 4'd1;
            end
        end else begin
            step_next_s = step_r;
        end
    end

    // Lamp pattern selection; patterns come from the next step so the lamps
    // change on the same edge as the step.
    always_comb begin
        lsb_s      = fill_lsb(int'(step_next_s), LAMPS);
        msb_s      = fill_msb(int'(step_next_s), LAMPS);
        unused_s   = ^{lsb_s, msb_s};
        l_next_s   = '0;
        r_next_s   = '0;
        err_next_s = (mode_s == ERROR);
        case (mode_s)
            IDLE: begin
                l_next_s = brake_s ? '1 : '0;
                r_next_s = brake_s ? '1 : '0;
            end
            LEFT: begin
                l_next_s = lsb_s[LAMPS-1:0];
                r_next_s = brake_s ? '1 : '0;
            end
            RIGHT: begin
                l_next_s = brake_s ? '1 : '0;
                r_next_s = msb_s[LAMPS-1:0];
            end
            HAZARD: begin
                // Both sides always equal, so l_signal alone holds the phase.
                if (entry_s) begin
                    l_next_s = '1;
                    r_next_s = '1;
                end else if (tick_s) begin
                    l_next_s = (l_signal == '0) ? '1 : '0;
                    r_next_s = (l_signal == '0) ? '1 : '0;
                end else begin
                    l_next_s = l_signal;
                    r_next_s = r_signal;
                end
            end
            ERROR: begin
                l_next_s = brake_s ? '1 : '0;
                r_next_s = brake_s ? '1 : '0;
            end
            default: begin
                l_next_s = '0;
                r_next_s = '0;
            end
        endcase
    end

    // Mode, step and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_r   <= IDLE;
            step_r   <= 4'd0;
            l_signal <= '0;
            r_signal <= '0;
            error    <= 1'b0;
        end else begin
            mode_r   <= mode_s;
            step_r   <= step_next_s;
            l_signal <= l_next_s;
            r_signal <= r_next_s;
            error    <= err_next_s;
        end
    end

endmodule

// File: tb/tb_turn_seq.sv
// -----------------------------------------------------------------------------
// tb_turn_seq
// Directed bench for turn_seq. Three instances share the inputs:
//   u_dut_a : LAMPS=3, TICK_DIV=1
//   u_dut_b : LAMPS=4, TICK_DIV=4
//   u_dut_c : LAMPS=3, TICK_DIV=2
// Each phase checks the instance whose configuration it targets.
// -----------------------------------------------------------------------------
module tb_turn_seq;

    logic       clock;
    logic       reset_n;
    logic       left;
    logic       right;
    logic       hazard;
    logic       brake;
    logic [2:0] l_a, r_a, l_c, r_c;
    logic [3:0] l_b, r_b;
    logic       err_a, err_b, err_c;

    int n_checks = 0;
    int n_errors = 0;

    turn_seq #(.LAMPS(3), .TICK_DIV(1)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
`ifdef TURN_SEQ_BRAKE_EN
        .brake(brake),
`endif
        .l_signal(l_a), .r_signal(r_a), .error(err_a)
    );

    turn_seq #(.LAMPS(4), .TICK_DIV(4)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
`ifdef TURN_SEQ_BRAKE_EN
        .brake(brake),
`endif
        .l_signal(l_b), .r_signal(r_b), .error(err_b)
    );

    turn_seq #(.LAMPS(3), .TICK_DIV(2)) u_dut_c (
        .clock(clock), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
`ifdef TURN_SEQ_BRAKE_EN
        .brake(brake),
`endif
        .l_signal(l_c), .r_signal(r_c), .error(err_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [2:0] left_pat [8];
    logic [3:0] right_pat [5];
    logic [2:0] haz_pat [5];

    initial begin
        left_pat  = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
        right_pat = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000};
        haz_pat   = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b111};

        reset_n = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        hazard  = 1'b0;
        brake   = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_l", 8'(l_a), 8'd0);
        check("rst_r", 8'(r_a), 8'd0);
        check("rst_err", 8'(err_a), 8'd0);
        check("rst_lb", 8'(l_b), 8'd0);

        // Left held, LAMPS=3, TICK_DIV=1
        reset_n = 1'b1;
        left    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("left_l%0d", i), 8'(l_a), 8'(left_pat[i]));
            check($sformatf("left_r%0d", i), 8'(r_a), 8'd0);
            check($sformatf("left_e%0d", i), 8'(err_a), 8'd0);
        end
        left = 1'b0;
        tick();
        check("idle_l", 8'(l_a), 8'd0);

        // Right held, LAMPS=4, TICK_DIV=4
        right = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            check($sformatf("right_b%0d", c), 8'(r_b), 8'(right_pat[((c - 1) / 4) % 5]));
            check($sformatf("right_bl%0d", c), 8'(l_b), 8'd0);
        end
        right = 1'b0;
        tick();

        // Direct left -> right switch, then error
        left = 1'b1;
        tick();
        tick();
        check("sw_l011", 8'(l_a), 8'b011);
        left  = 1'b0;
        right = 1'b1;
        tick();
        check("sw_l", 8'(l_a), 8'b000);
        check("sw_r", 8'(r_a), 8'b100);
        left = 1'b1;
        #1;
        check("err_noncomb", 8'(err_a), 8'd0);
        tick();
        check("err_l", 8'(l_a), 8'd0);
        check("err_r", 8'(r_a), 8'd0);
        check("err_set", 8'(err_a), 8'd1);
        tick();
        check("err_hold", 8'(err_a), 8'd1);
        left  = 1'b0;
        right = 1'b0;
        #1;
        check("err_still", 8'(err_a), 8'd1);
        tick();
        check("err_clr", 8'(err_a), 8'd0);

        // Hazard overriding left&right, TICK_DIV=2
        hazard = 1'b1;
        left   = 1'b1;
        right  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("haz_l%0d", i), 8'(l_c), 8'(haz_pat[i]));
            check($sformatf("haz_r%0d", i), 8'(r_c), 8'(haz_pat[i]));
            check($sformatf("haz_e%0d", i), 8'(err_c), 8'd0);
        end
        hazard = 1'b0;
        right  = 1'b0;
        tick();
        check("haz_drop_l", 8'(l_c), 8'b001);
        check("haz_drop_r", 8'(r_c), 8'b000);

        // Asynchronous reset mid-sequence
        check("pre_rst_a1", 8'(l_a), 8'b001);
        tick();
        check("pre_rst_a2", 8'(l_a), 8'b011);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_l", 8'(l_a), 8'd0);
        check("async_r", 8'(r_a), 8'd0);
        check("async_lc", 8'(l_c), 8'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_l", 8'(l_a), 8'b001);

`ifdef TURN_SEQ_BRAKE_EN
        // Brake overlay
        left  = 1'b0;
        brake = 1'b1;
        tick();
        check("brk_idle_l", 8'(l_a), 8'b111);
        check("brk_idle_r", 8'(r_a), 8'b111);
        left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("brk_left_l%0d", i), 8'(l_a), 8'(left_pat[i]));
            check($sformatf("brk_left_r%0d", i), 8'(r_a), 8'b111);
        end
        brake = 1'b0;
        left  = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
